can_xmit_arb: RTL and testbench
===============================

CAN_XMIT_ARB -- requirements
Module: can_xmit_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of transmit requesters (mailboxes), legal range 2..8.
REQ-002 SHALL have parameter BUSY_TMO, default 16, cycles allowed between startXmit and busy rising.
REQ-003 SHALL have port HCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port HRESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  NREQ  per-requester transmit request; level, held until done or err.
REQ-006 SHALL have port req_id  input  NREQ x 29  per-requester CAN identifier.
REQ-007 SHALL have port req_data  input  NREQ x 64  per-requester payload, {DH,DL}.
REQ-008 SHALL have port req_cmd  input  NREQ x 32  per-requester CMD word: [31:24] quantaDiv, [23:18] propQuanta, [17:12] seg1Quanta, [11:8] datalen, [7] format, [6:5] frameType.
REQ-009 SHALL have port done  output  NREQ  one-cycle pulse to the served requester on successful completion.
REQ-010 SHALL have port err  output  NREQ  one-cycle pulse to the served requester on busy timeout.
REQ-011 SHALL have port startXmit  output  1  one-cycle start pulse to the CAN transmitter.
REQ-012 SHALL have ports xmitdata(64), quantaDiv(8), propQuanta(6), seg1Quanta(6), datalen(4), format(1), frameType(2), id(29), all outputs, registered, driving the transmitter.
REQ-013 SHALL have port busy  input  1  transmitter busy status.
REQ-014 SHALL have port active  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, START, WAIT_RISE, WAIT_FALL and RESP.
REQ-016 IDLE: if any req bit is set and unmasked, SHALL select the requester with the numerically lowest req_id, breaking ties by lowest index, latch its index and fields into the output registers, and go to START.
REQ-017 START: SHALL assert startXmit for exactly one cycle, load the timeout counter with BUSY_TMO, and go to WAIT_RISE.
REQ-018 WAIT_RISE: busy=1 SHALL go to WAIT_FALL; otherwise the counter SHALL decrement; when the counter reaches 0, SHALL set the error flag and go to RESP.
REQ-019 WAIT_FALL: busy=0 SHALL go to RESP with the error flag clear; WAIT_FALL SHALL have no timeout.
REQ-020 RESP: SHALL pulse done[sel] or err[sel] for one cycle, then return to IDLE.
REQ-021 Latency from req rising in IDLE to startXmit SHALL be 2 cycles (IDLE decision, START asserting).
REQ-022 Latched fields SHALL stay stable from START until the next IDLE selection; changes on req_* after selection SHALL have no effect.
REQ-023 Dropping req[sel] after selection SHALL NOT abort the transfer; done/err SHALL still be pulsed.
REQ-024 The requester served in RESP SHALL be masked from selection in the IDLE cycle that immediately follows, so the other requesters get one arbitration opportunity.
REQ-025 busy already high in START SHALL be accepted in WAIT_RISE on the next cycle; no edge detection is required.
REQ-026 At most one done/err bit SHALL be high in any cycle.
REQ-027 Unknown or illegal state encodings SHALL return to IDLE.

Reset
REQ-028 On HRESET low, the block SHALL immediately enter IDLE and clear done, err, startXmit, active, the mask, the counter and all field registers to 0, regardless of the current state.
REQ-029 A transfer in progress when reset is asserted SHALL be abandoned without a done or err pulse.

Structure
REQ-030 A shared package can_pkg SHALL hold the state enum, the CMD field bit positions, and the types can_id_t (29 b) and can_cmd_t.
REQ-031 The lowest-ID selection SHALL be a combinational sub-module can_id_prio (inputs req, mask, ids; outputs valid and index).

Verification
REQ-032 req=4'b0001 with id0=0x100 and busy rising 3 cycles after startXmit, high for 10 cycles -> startXmit 2 cycles after req, xmitdata/id match mailbox 0, done[0] 1 cycle after busy falls.
REQ-033 req=4'b1010 with id1=0x1FF and id3=0x0A0 -> mailbox 3 is served first, then mailbox 1 with no extra idle cycle beyond the mask cycle.
REQ-034 Equal ids of 0x55 on req 0 and 2 -> index 0 is served first.
REQ-035 busy held 0 after startXmit -> err[sel] pulses BUSY_TMO+1 cycles after startXmit, done stays 0.
REQ-036 HRESET asserted during WAIT_FALL -> all outputs go to 0 asynchronously, no done pulse; after release with req still set, selection restarts.
REQ-037 req[sel] dropped in WAIT_FALL and req_data changed -> xmitdata unchanged and done[sel] still pulses.

Source files
------------

// File: rtl/can_pkg.sv
// Shared types for the CAN transmit arbiter: FSM states, identifier and
// CMD word layouts.
package can_pkg;

  typedef logic [28:0] can_id_t;
  typedef logic [31:0] can_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_WAIT_FALL = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  // CMD word field positions
  localparam int CMD_QDIV_MSB  = 31;
  localparam int CMD_QDIV_LSB  = 24;
  localparam int CMD_PROP_MSB  = 23;
  localparam int CMD_PROP_LSB  = 18;
  localparam int CMD_SEG1_MSB  = 17;
  localparam int CMD_SEG1_LSB  = 12;
  localparam int CMD_DLEN_MSB  = 11;
  localparam int CMD_DLEN_LSB  = 8;
  localparam int CMD_FMT_BIT   = 7;
  localparam int CMD_FTYPE_MSB = 6;
  localparam int CMD_FTYPE_LSB = 5;
  localparam int CMD_RSVD_MSB  = 4;

endpackage

// File: rtl/can_id_prio.sv
// Combinational lowest-identifier picker; ties resolve to the lowest index
// because only a strictly smaller id displaces the current winner.
module can_id_prio
  import can_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic                   [NREQ-1:0] req,
  input  logic                   [NREQ-1:0] mask,
  input  can_id_t [NREQ-1:0]                ids,
  output logic                              valid,
  output logic                   [IW-1:0]   index
);

  can_id_t best_id;

  always_comb begin
    valid   = 1'b0;
    index   = '0;
    best_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !mask[i] && (!valid || ids[i] < best_id)) begin
        valid   = 1'b1;
        index   = IW'(i);
        best_id = ids[i];
      end
    end
  end

endmodule

// File: rtl/can_xmit_arb.sv
// Arbitrates mailbox transmit requests by lowest CAN id, hands the winner's
// fields to the transmitter and reports done/err back to that mailbox.
module can_xmit_arb
  import can_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int BUSY_TMO = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic      [NREQ-1:0]     req,
  input  can_id_t   [NREQ-1:0]     req_id,
  input  logic      [NREQ-1:0][63:0] req_data,
  input  can_cmd_t  [NREQ-1:0]     req_cmd,
  output logic      [NREQ-1:0]     done,
  output logic      [NREQ-1:0]     err,
  output logic                     startXmit,
  output logic      [63:0]         xmitdata,
  output logic      [7:0]          quantaDiv,
  output logic      [5:0]          propQuanta,
  output logic      [5:0]          seg1Quanta,
  output logic      [3:0]          datalen,
  output logic                     format,
  output logic      [1:0]          frameType,
  output can_id_t                  id,
  input  logic                     busy,
  output logic                     active,
  output state_t                   state
);

  localparam int IW    = $clog2(NREQ);
  localparam int CNT_W = $clog2(BUSY_TMO + 1);

  logic [NREQ-1:0]  mask;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  sel_bit;
  can_cmd_t         pick_cmd;
  logic             unused_rsvd;

  can_id_prio #(.NREQ(NREQ), .IW(IW)) u_prio (
    .req   (req),
    .mask  (mask),
    .ids   (req_id),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign sel_bit     = NREQ'(1) << sel;
  assign pick_cmd    = req_cmd[pick_idx];
  assign unused_rsvd = ^pick_cmd[CMD_RSVD_MSB:0];

  // Handshake: startXmit is high for the single cycle after START; busy is
  // level-sampled (high may already be present), and the done/err pulse is
  // high exactly while the FSM sits in RESP.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state      <= S_IDLE;
      done       <= '0;
      err        <= '0;
      startXmit  <= 1'b0;
      active     <= 1'b0;
      mask       <= '0;
      sel        <= '0;
      cnt        <= '0;
      xmitdata   <= '0;
      quantaDiv  <= '0;
      propQuanta <= '0;
      seg1Quanta <= '0;
      datalen    <= '0;
      format     <= 1'b0;
      frameType  <= '0;
      id         <= '0;
    end else begin
      done      <= '0;
      err       <= '0;
      startXmit <= 1'b0;
      case (state)
        S_IDLE: begin
          // The mask only spans the one IDLE cycle after a response
          mask <= '0;
          if (pick_valid) begin
            sel        <= pick_idx;
            xmitdata   <= req_data[pick_idx];
            id         <= req_id[pick_idx];
            quantaDiv  <= pick_cmd[CMD_QDIV_MSB:CMD_QDIV_LSB];
            propQuanta <= pick_cmd[CMD_PROP_MSB:CMD_PROP_LSB];
            seg1Quanta <= pick_cmd[CMD_SEG1_MSB:CMD_SEG1_LSB];
            datalen    <= pick_cmd[CMD_DLEN_MSB:CMD_DLEN_LSB];
            format     <= pick_cmd[CMD_FMT_BIT];
            frameType  <= pick_cmd[CMD_FTYPE_MSB:CMD_FTYPE_LSB];
            active     <= 1'b1;
            state      <= S_START;
          end else begin
            active <= 1'b0;
          end
        end
        S_START: begin
          startXmit <= 1'b1;
          cnt       <= CNT_W'(BUSY_TMO);
          state     <= S_WAIT_RISE;
        end
        S_WAIT_RISE: begin
          if (busy) begin
            state <= S_WAIT_FALL;
          end else if (cnt == '0) begin
            err   <= sel_bit;
            state <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WAIT_FALL: begin
          if (!busy) begin
            done  <= sel_bit;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          mask   <= sel_bit;
          active <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          mask   <= '0;
          active <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_xmit_arb.sv
// Directed bench for can_xmit_arb: arbitration order, latency, timeout,
// mid-transfer reset and post-selection input changes.
module tb_can_xmit_arb;
  import can_pkg::*;

  localparam int NREQ     = 4;
  localparam int BUSY_TMO = 16;

  logic                      HCLK = 1'b0;
  logic                      HRESET = 1'b0;
  logic      [NREQ-1:0]      req;
  can_id_t   [NREQ-1:0]      req_id;
  logic      [NREQ-1:0][63:0] req_data;
  can_cmd_t  [NREQ-1:0]      req_cmd;
  logic      [NREQ-1:0]      done;
  logic      [NREQ-1:0]      err;
  logic                      startXmit;
  logic      [63:0]          xmitdata;
  logic      [7:0]           quantaDiv;
  logic      [5:0]           propQuanta;
  logic      [5:0]           seg1Quanta;
  logic      [3:0]           datalen;
  logic                      format;
  logic      [1:0]           frameType;
  can_id_t                   id;
  logic                      busy;
  logic                      active;
  state_t                    state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  can_xmit_arb #(.NREQ(NREQ), .BUSY_TMO(BUSY_TMO)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .req        (req),
    .req_id     (req_id),
    .req_data   (req_data),
    .req_cmd    (req_cmd),
    .done       (done),
    .err        (err),
    .startXmit  (startXmit),
    .xmitdata   (xmitdata),
    .quantaDiv  (quantaDiv),
    .propQuanta (propQuanta),
    .seg1Quanta (seg1Quanta),
    .datalen    (datalen),
    .format     (format),
    .frameType  (frameType),
    .id         (id),
    .busy       (busy),
    .active     (active),
    .state      (state)
  );

  // clock / watchdog
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // any response pulse must be one-hot
  always @(negedge HCLK) begin
    if (HRESET && (done | err) != '0)
      check("pulse_onehot", 64'($countones({done, err})), 64'd1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic set_mbx(input int i, input can_id_t vid, input logic [63:0] vdata, input can_cmd_t vcmd);
    req_id[i]   = vid;
    req_data[i] = vdata;
    req_cmd[i]  = vcmd;
  endtask

  // Serves the next mailbox from exp_q. Called on a negedge; lat returns the
  // number of negedges until startXmit was seen.
  task automatic serve(input int rise_dly, input int hi_len, input bit timeout,
                       input bit corrupt, output int lat);
    logic [2:0]      idx;
    logic [63:0]     e_data;
    can_id_t         e_id;
    can_cmd_t        e_cmd;
    logic [NREQ-1:0] e_bit;
    int              k;
    lat = -1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'd1, 64'd0);
      return;
    end
    idx    = exp_q.pop_front();
    e_data = req_data[idx];
    e_id   = req_id[idx];
    e_cmd  = req_cmd[idx];
    e_bit  = '0;
    e_bit[idx] = 1'b1;
    lat = 0;
    while (!startXmit && lat < 30) begin
      @(negedge HCLK);
      lat++;
    end
    if (!startXmit) begin
      check("start_seen", 64'd0, 64'd1);
      return;
    end
    check("sx_id", id, e_id);
    check("sx_data", xmitdata, e_data);
    check("sx_cmd", {quantaDiv, propQuanta, seg1Quanta, datalen, format, frameType}, e_cmd[31:5]);
    @(negedge HCLK);
    check("sx_one_cycle", startXmit, 1'b0);
    if (timeout) begin
      k = 1;
      while (err == '0 && done == '0 && k < 40) begin
        @(negedge HCLK);
        k++;
      end
      check("tmo_latency", k, BUSY_TMO + 1);
      check("tmo_err", err, e_bit);
      check("tmo_done", done, '0);
    end else begin
      repeat (rise_dly - 1) @(negedge HCLK);
      busy = 1'b1;
      repeat (2) @(negedge HCLK);
      if (corrupt) begin
        req[idx]      = 1'b0;
        req_data[idx] = ~e_data;
        req_id[idx]   = '0;
      end
      repeat (hi_len - 2) @(negedge HCLK);
      check("busy_no_done", done, '0);
      check("busy_active", active, 1'b1);
      busy = 1'b0;
      @(negedge HCLK);
      check("done_vec", done, e_bit);
      check("err_vec", err, '0);
      check("data_hold", xmitdata, e_data);
    end
    req[idx] = 1'b0;
  endtask

  initial begin
    int lat;
    req  = '0;
    busy = 1'b0;
    for (int i = 0; i < NREQ; i++) set_mbx(i, 29'h1FFFFFFF, 64'h0, 32'h0);

    // reset state
    idle(2);
    check("rst_state", state, S_IDLE);
    check("rst_active", active, 1'b0);
    check("rst_start", startXmit, 1'b0);
    check("rst_resp", {done, err}, '0);
    check("rst_data", xmitdata, 64'h0);
    HRESET = 1'b1;
    idle(2);

    // single request: latency 2, fields, done after busy falls
    set_mbx(0, 29'h100, 64'h0123_4567_89AB_CDEF, 32'hA58C_37E0);
    req = 4'b0001;
    exp_q.push_back(3'd0);
    serve(3, 10, 1'b0, 1'b0, lat);
    check("t1_latency", lat, 2);
    @(negedge HCLK);
    check("t1_done_clear", done, '0);
    check("t1_idle", active, 1'b0);
    idle(3);

    // lower id wins; the other follows right after the mask cycle
    set_mbx(1, 29'h1FF, 64'h1111_2222_3333_4444, 32'h1234_5660);
    set_mbx(3, 29'h0A0, 64'h5555_6666_7777_8888, 32'hFEDC_BA80);
    req = 4'b1010;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd1);
    serve(1, 4, 1'b0, 1'b0, lat);
    serve(2, 5, 1'b0, 1'b0, lat);
    check("t2_gap", lat, 3);
    idle(3);

    // equal ids: lowest index first
    set_mbx(0, 29'h55, 64'hAAAA_0000_AAAA_0000, 32'h0F0F_0F00);
    set_mbx(2, 29'h55, 64'hBBBB_0000_BBBB_0000, 32'hF0F0_F0E0);
    req = 4'b0101;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd2);
    serve(2, 3, 1'b0, 1'b0, lat);
    serve(2, 3, 1'b0, 1'b0, lat);
    check("t3_gap", lat, 3);
    idle(3);

    // busy never rises: timeout error
    set_mbx(2, 29'h7, 64'hDEAD_BEEF_0000_0001, 32'h0101_0120);
    req = 4'b0100;
    exp_q.push_back(3'd2);
    serve(0, 0, 1'b1, 1'b0, lat);
    @(negedge HCLK);
    check("t4_err_clear", err, '0);
    idle(3);

    // reset during WAIT_FALL
    set_mbx(0, 29'h42, 64'hCAFE_F00D_1234_5678, 32'h7777_7760);
    req = 4'b0001;
    lat = 0;
    while (!startXmit && lat < 30) begin
      @(negedge HCLK);
      lat++;
    end
    check("t5_start", startXmit, 1'b1);
    @(negedge HCLK);
    busy = 1'b1;
    idle(3);
    check("t5_in_wait_fall", state, S_WAIT_FALL);
    #2 HRESET = 1'b0;
    #1;
    check("t5_rst_state", state, S_IDLE);
    check("t5_rst_active", active, 1'b0);
    check("t5_rst_fields", {xmitdata, id}, '0);
    check("t5_rst_cmd", {quantaDiv, propQuanta, seg1Quanta, datalen, format, frameType}, '0);
    busy = 1'b0;
    @(negedge HCLK);
    check("t5_no_done_a", {done, err, startXmit}, '0);
    @(negedge HCLK);
    check("t5_no_done_b", {done, err, startXmit}, '0);
    HRESET = 1'b1;
    exp_q.push_back(3'd0);
    serve(2, 3, 1'b0, 1'b0, lat);
    check("t5_restart_lat", lat, 2);
    idle(3);

    // inputs change after selection: latched fields hold, done still pulses
    set_mbx(1, 29'h3C, 64'h0F1E_2D3C_4B5A_6978, 32'h3344_5500);
    req = 4'b0010;
    exp_q.push_back(3'd1);
    serve(1, 6, 1'b0, 1'b1, lat);
    idle(3);
    check("t6_idle", active, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
